// File: rtl/mul4_acc_pkg.sv
// Shared types and constants for the mul4_accumulator slice.
// The optional saturating mode is selected in the top file with MUL4_ACC_SAT_EN.
package mul4_acc_pkg;

  // Operand and product widths of the 4x4 unsigned multiplier
  localparam int OPND_W = 4;
  localparam int PROD_W = 8;

  // ACC gathers beats of a packet, HOLD presents the finished sum
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mul4_accumulator_mult.sv
// Existing purely combinational 4x4 unsigned multiplier used as the
// product generator of mul4_accumulator.
module Multiple_4bit (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [7:0] s
);

  // Zero-extend both operands so the full 8-bit product is kept
  assign s = {4'b0000, X} * {4'b0000, Y};

endmodule

// File: rtl/mul4_accumulator.sv
// Sequential multiply-accumulate stage: sums the products of a packet of
// 4-bit operand pairs and presents one sum per packet on a valid/ready
// output handshake.
// Optional macro MUL4_ACC_SAT_EN: when defined, the accumulator clamps to
// its maximum value on overflow instead of wrapping around.
module mul4_accumulator
  import mul4_acc_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_x,
  input  logic [OPND_W-1:0] in_y,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int SUM_W = ACC_W + 1;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [PROD_W-1:0]  prod;
  logic [SUM_W-1:0]   sum_n;
  logic               carry;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_inc;

  Multiple_4bit u_mult (
    .X (in_x),
    .Y (in_y),
    .s (prod)
  );

  // The extra top bit of the sum captures the carry out of the accumulator
  assign sum_n   = {1'b0, acc_q} + SUM_W'(prod);
  assign carry   = sum_n[ACC_W];
  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef MUL4_ACC_SAT_EN
  // Once the packet has overflowed the accumulator stays pinned at its maximum
  assign acc_next = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_n[ACC_W-1:0];
`else
  // Plain modulo arithmetic: the carry is dropped and only flagged
  assign acc_next = sum_n[ACC_W-1:0];
`endif

  assign in_ready  = (state_q == ACC);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Next-state logic: accumulate beats in ACC, wait for the consumer in HOLD
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (in_last) begin
            out_sum_d   = acc_next;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | carry;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mul4_accumulator.sv
// Self-checking bench for mul4_accumulator: fixed vector table, hand-written
// corner sequences and random packets against an arithmetic reference model.
// Build with MUL4_ACC_SAT_EN defined to check the saturating variant.
module tb_mul4_accumulator;

  localparam int     ACC_W = 12;
  localparam int     CNT_W = 5;
  localparam longint MAXV  = longint'(1) << ACC_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_x;
  logic [3:0]       in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]       x;
    logic [3:0]       y;
    logic             last;
    logic [ACC_W-1:0] eSum;
    logic [CNT_W-1:0] eCnt;
    logic             eOvf;
  } vec_t;

  vec_t vecs[7];

  mul4_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: true sum of the products, then wrap or clamp
  task automatic modelPacket(input int n, input longint total,
                             output longint eSum, output int eCnt, output bit eOvf);
    eOvf = (total >= MAXV);
`ifdef MUL4_ACC_SAT_EN
    eSum = eOvf ? (MAXV - 1) : total;
`else
    eSum = total % MAXV;
`endif
    eCnt = n % (1 << CNT_W);
  endtask

  // Offer one beat and wait (bounded) until it is accepted
  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input logic last);
    bit done;
    done = 1'b0;
    in_x = x;
    in_y = y;
    in_last = last;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got in_ready=0 expected 1 within 20 cycles");
    end
  endtask

  // Called right after the last beat was accepted: result must already be valid
  task automatic checkResult(input string name, input longint eSum, input int eCnt, input bit eOvf);
    checkOutput({name, ".valid"}, 64'(out_valid), 64'd1);
    checkOutput({name, ".sum"}, 64'(out_sum), 64'(eSum));
    checkOutput({name, ".count"}, 64'(out_count), 64'(eCnt));
    checkOutput({name, ".ovf"}, 64'(out_ovf), 64'(eOvf));
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("releaseValid", 64'(out_valid), 64'd0);
    checkOutput("releaseReady", 64'(in_ready), 64'd1);
  endtask

  initial begin
    longint total, eSum;
    int     eCnt, n, x, y;
    bit     eOvf;

    vecs[0] = '{x: 4'd2,  y: 4'd2,  last: 1'b1, eSum: 12'd4,   eCnt: 5'd1, eOvf: 1'b0};
    vecs[1] = '{x: 4'd10, y: 4'd2,  last: 1'b0, eSum: 12'd0,   eCnt: 5'd0, eOvf: 1'b0};
    vecs[2] = '{x: 4'd6,  y: 4'd10, last: 1'b0, eSum: 12'd0,   eCnt: 5'd0, eOvf: 1'b0};
    vecs[3] = '{x: 4'd11, y: 4'd3,  last: 1'b0, eSum: 12'd0,   eCnt: 5'd0, eOvf: 1'b0};
    vecs[4] = '{x: 4'd15, y: 4'd3,  last: 1'b1, eSum: 12'd158, eCnt: 5'd4, eOvf: 1'b0};
    vecs[5] = '{x: 4'd0,  y: 4'd15, last: 1'b1, eSum: 12'd0,   eCnt: 5'd1, eOvf: 1'b0};
    vecs[6] = '{x: 4'd15, y: 4'd15, last: 1'b1, eSum: 12'd225, eCnt: 5'd1, eOvf: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstReady", 64'(in_ready), 64'd1);
    checkOutput("rstSum", 64'(out_sum), 64'd0);
    checkOutput("rstCount", 64'(out_count), 64'd0);
    checkOutput("rstOvf", 64'(out_ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].last);
      if (vecs[i].last) begin
        checkResult($sformatf("vec%0d", i), longint'(vecs[i].eSum), int'(vecs[i].eCnt), vecs[i].eOvf);
        releaseResult();
      end else begin
        checkOutput($sformatf("vec%0dNoValid", i), 64'(out_valid), 64'd0);
      end
    end

    // Overflow: 19 beats of 15*15 = 4275
    for (int i = 0; i < 18; i++) applyStimulus(4'd15, 4'd15, 1'b0);
    applyStimulus(4'd15, 4'd15, 1'b1);
`ifdef MUL4_ACC_SAT_EN
    checkResult("ovf19", 4095, 19, 1'b1);
`else
    checkResult("ovf19", 179, 19, 1'b1);
`endif
    releaseResult();

    // Backpressure with a beat offered during HOLD
    applyStimulus(4'd7, 4'd5, 1'b1);
    checkResult("bp", 35, 1, 1'b0);
    in_x = 4'd9;
    in_y = 4'd9;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bpValid", 64'(out_valid), 64'd1);
      checkOutput("bpReady", 64'(in_ready), 64'd0);
      checkOutput("bpSum", 64'(out_sum), 64'd35);
      checkOutput("bpCount", 64'(out_count), 64'd1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    releaseResult();
    checkOutput("bpHeldSum", 64'(out_sum), 64'd35);
    applyStimulus(4'd3, 4'd3, 1'b1);
    checkResult("bpNext", 9, 1, 1'b0);
    releaseResult();

    // Exhaustive single-beat packets
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), 1'b1);
        checkOutput("exhSum", 64'(out_sum), 64'(a * b));
        checkOutput("exhCount", 64'(out_count), 64'd1);
        releaseResult();
      end
    end

    // Reset in the middle of a packet
    for (int i = 0; i < 3; i++) applyStimulus(4'd15, 4'd15, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midRstValid", 64'(out_valid), 64'd0);
    checkOutput("midRstReady", 64'(in_ready), 64'd1);
    checkOutput("midRstSum", 64'(out_sum), 64'd0);
    checkOutput("midRstCount", 64'(out_count), 64'd0);
    applyStimulus(4'd3, 4'd3, 1'b1);
    checkResult("midRst", 9, 1, 1'b0);
    releaseResult();

    // Random packets with idle gaps and random release delays
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 40);
      total = 0;
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 2)) begin
          in_x = 4'($urandom);
          in_y = 4'($urandom);
          @(posedge clk); #1;
        end
        x = $urandom_range(0, 15);
        y = $urandom_range(0, 15);
        total += longint'(x * y);
        applyStimulus(4'(x), 4'(y), b == n - 1);
      end
      modelPacket(n, total, eSum, eCnt, eOvf);
      checkResult($sformatf("rnd%0d", p), eSum, eCnt, eOvf);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      releaseResult();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul4_accumulator.md
Name: mul4_accumulator

Overview:
- Sequential multiply-accumulate stage directly downstream of the 4-bit combinational multiplier.
- Accepts a packet of 4-bit operand pairs over a valid/ready handshake and multiplies each pair.
- Sums the 8-bit products into a wide accumulator and presents one sum per packet on an output handshake.
- Used wherever dot products or sums of products of 4-bit values are needed.

Parameters:
- ACC_W, 12, accumulator and out_sum width; legal range 8..32.
- CNT_W, 5, beat counter and out_count width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_x  input  4  multiplicand, unsigned.
- in_y  input  4  multiplier, unsigned.
- in_last  input  1  marks the final beat of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  packet sum of products.
- out_count  output  CNT_W  number of beats in the packet.
- out_ovf  output  1  accumulator overflowed during the packet.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n and is sampled only on the clk rising edge.
- Reset values: state=ACC, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, ovf_flag=0.
- States:
  - ACC: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Beat accept: in_valid && in_ready at a rising edge. The product p = in_x*in_y is 8 bits, combinational, and zero-extended to ACC_W+1 bits. sum_n = acc + p; a carry into bit ACC_W is an overflow.
- Non-last beat: acc<=sum_n[ACC_W-1:0]; cnt<=cnt+1, wrapping mod 2^CNT_W; ovf_flag|=carry. State stays ACC.
- Last beat:
  - out_sum<=sum_n[ACC_W-1:0], out_count<=cnt+1, out_ovf<=ovf_flag|carry.
  - acc, cnt and ovf_flag clear to 0; state goes to HOLD.
  - Latency: the result is valid the cycle after the last beat is accepted.
- HOLD:
  - out_sum, out_count and out_ovf are stable.
  - out_valid && out_ready -> out_valid<=0 and state goes to ACC. in_ready=1 from the next cycle; no beat is accepted in the release cycle.
  - out_ready low holds the state indefinitely.
- in_valid low in ACC: no change. Inputs are ignored when not accepted.
- A single-beat packet (in_last on the first beat) is legal.
- Reset mid-packet or in HOLD: the partial accumulation and any pending result are discarded, and all registers return to reset values.
- out_* hold their last values after release, until the next packet's last beat.

Optional Feature:
- Macro MUL4_ACC_SAT_EN.
- Defined: on carry, acc (or out_sum on the last beat) clamps to 2^ACC_W-1 and stays clamped for the rest of the packet. out_ovf has the same meaning.
- Undefined: wrap-around modulo 2^ACC_W as above.

Decomposition:
- Package mul4_acc_pkg:
  - state enum (ACC, HOLD).
  - constants OPND_W=4 and PROD_W=8.
- Sub-module: one instance of the existing Multiple_4bit combinational multiplier (X, Y -> s[7:0]) generates p. All sequential logic lives in mul4_accumulator.

Test Plan:
- Single beat x=2, y=2, in_last=1 -> next cycle out_valid=1, out_sum=4, out_count=1, out_ovf=0.
- Packet (10,2),(6,10),(11,3),(15,3 last) -> out_sum=158, out_count=4, out_ovf=0.
- Overflow, ACC_W=12, 19 beats of (15,15):
  - without MUL4_ACC_SAT_EN -> out_sum=179, out_ovf=1, out_count=19.
  - with MUL4_ACC_SAT_EN -> out_sum=4095, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid=1, in_ready=0, outputs stable; a beat offered during HOLD is not accepted; after release, the next packet (3,3 last) gives out_sum=9.
- Exhaustive: all 256 (x,y) pairs as single-beat packets with out_ready=1 -> out_sum=x*y and out_count=1 for each.
- Reset mid-packet: 3 beats (15,15), then rst_n=0 for 1 cycle, then (3,3 last) -> out_sum=9, out_count=1, out_ovf=0.
